// File: rtl/morse_enc.sv
// Morse letter encoder: one dit/dah symbol per cycle, then GAP_CYCLES separators; first symbol registered at the accept edge.
// Backpressure: ready only in IDLE or on the last gap cycle; valid while not ready is dropped, not queued.
module morse_enc #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] letter,
    input  logic       letter_valid,
    output logic       ready,
    output logic [1:0] ditDah,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] DIT = 2'b00;
    localparam logic [1:0] DAH = 2'b11;
    localparam logic [1:0] ETC = 2'b01;

    typedef enum logic [1:0] {IDLE, SYM, GAP} state_t;

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;   // remaining symbols, left-aligned, bit 4 sent next (1 = dah)
    logic [2:0] len_q, len_d;   // symbols still to send after the one on ditDah
    logic [3:0] gap_q, gap_d;
    logic [1:0] dd_q, dd_d;
    logic       err_q, err_d;

    logic [4:0] lut_pat;
    logic [2:0] lut_len;
    logic       lut_ok;
    logic       accept;

    // Patterns written first-sent-first, left-aligned and zero padded.
    always_comb begin
        lut_ok = 1'b1;
        case (letter)
            6'd0:  {lut_len, lut_pat} = {3'd2, 5'b01000}; // a
            6'd1:  {lut_len, lut_pat} = {3'd4, 5'b10000}; // b
            6'd2:  {lut_len, lut_pat} = {3'd4, 5'b10100}; // c
            6'd3:  {lut_len, lut_pat} = {3'd3, 5'b10000}; // d
            6'd4:  {lut_len, lut_pat} = {3'd1, 5'b00000}; // e
            6'd5:  {lut_len, lut_pat} = {3'd4, 5'b00100}; // f
            6'd6:  {lut_len, lut_pat} = {3'd3, 5'b11000}; // g
            6'd7:  {lut_len, lut_pat} = {3'd4, 5'b00000}; // h
            6'd8:  {lut_len, lut_pat} = {3'd2, 5'b00000}; // i
            6'd9:  {lut_len, lut_pat} = {3'd4, 5'b01110}; // j
            6'd10: {lut_len, lut_pat} = {3'd3, 5'b10100}; // k
            6'd11: {lut_len, lut_pat} = {3'd4, 5'b01000}; // l
            6'd12: {lut_len, lut_pat} = {3'd2, 5'b11000}; // m
            6'd13: {lut_len, lut_pat} = {3'd2, 5'b10000}; // n
            6'd14: {lut_len, lut_pat} = {3'd3, 5'b11100}; // o
            6'd15: {lut_len, lut_pat} = {3'd4, 5'b01100}; // p
            6'd16: {lut_len, lut_pat} = {3'd4, 5'b11010}; // q
            6'd17: {lut_len, lut_pat} = {3'd3, 5'b01000}; // r
            6'd18: {lut_len, lut_pat} = {3'd3, 5'b00000}; // s
            6'd19: {lut_len, lut_pat} = {3'd1, 5'b10000}; // t
            6'd20: {lut_len, lut_pat} = {3'd3, 5'b00100}; // u
            6'd21: {lut_len, lut_pat} = {3'd4, 5'b00010}; // v
            6'd22: {lut_len, lut_pat} = {3'd3, 5'b01100}; // w
            6'd23: {lut_len, lut_pat} = {3'd4, 5'b10010}; // x
            6'd24: {lut_len, lut_pat} = {3'd4, 5'b10110}; // y
            6'd25: {lut_len, lut_pat} = {3'd4, 5'b11000}; // z
            6'd26: {lut_len, lut_pat} = {3'd5, 5'b11111}; // 0
            6'd27: {lut_len, lut_pat} = {3'd5, 5'b01111}; // 1
            6'd28: {lut_len, lut_pat} = {3'd5, 5'b00111}; // 2
            6'd29: {lut_len, lut_pat} = {3'd5, 5'b00011}; // 3
            6'd30: {lut_len, lut_pat} = {3'd5, 5'b00001}; // 4
            6'd31: {lut_len, lut_pat} = {3'd5, 5'b00000}; // 5
            6'd32: {lut_len, lut_pat} = {3'd5, 5'b10000}; // 6
            6'd33: {lut_len, lut_pat} = {3'd5, 5'b11000}; // 7
            6'd34: {lut_len, lut_pat} = {3'd5, 5'b11100}; // 8
            6'd35: {lut_len, lut_pat} = {3'd5, 5'b11110}; // 9
            6'd36: {lut_len, lut_pat} = {3'd4, 5'b00110}; // space
            default: begin
                {lut_len, lut_pat} = {3'd0, 5'b00000};
                lut_ok             = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            dd_q    <= ETC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            dd_q    <= dd_d;
            err_q   <= err_d;
        end
    end

    assign accept = letter_valid && ready;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        dd_d    = dd_q;
        err_d   = 1'b0;
        case (state_q)
            SYM: begin
                if (len_q == 3'd0) begin
                    state_d = GAP;
                    dd_d    = ETC;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end else begin
                    dd_d  = pat_q[4] ? DAH : DIT;
                    pat_d = {pat_q[3:0], 1'b0};
                    len_d = len_q - 3'd1;
                end
            end
            GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
            end
            default: state_d = IDLE;
        endcase
        // Acceptance overrides the gap countdown so a new letter follows the last gap directly.
        if (accept) begin
            pat_d = '0;
            len_d = '0;
            gap_d = '0;
            if (lut_ok) begin
                state_d = SYM;
                dd_d    = lut_pat[4] ? DAH : DIT;
                pat_d   = {lut_pat[3:0], 1'b0};
                len_d   = lut_len - 3'd1;
            end else begin
                state_d = IDLE;
                dd_d    = ETC;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        ready  = (state_q == IDLE) || ((state_q == GAP) && (gap_q == 4'd0));
        busy   = (state_q != IDLE);
        ditDah = dd_q;
        err    = err_q;
    end

endmodule

// File: doc/morse_enc.md
MORSE_ENC -- requirements
Module: morse_enc

Interface
REQ-001 Parameter: GAP_CYCLES, default 1, number of separator (`etc`) cycles after each letter; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: letter  input  6  letter code: 0..25 = a..z, 26..35 = digits 0..9, 36 = SPACE, 37..63 = invalid.
REQ-005 Port: letter_valid  input  1  letter holds a code to encode.
REQ-006 Port: ready  output  1  encoder accepts a letter this cycle.
REQ-007 Port: ditDah  output  2  symbol stream: dit = 2'b00, dah = 2'b11, etc (separator/idle) = 2'b01; same encoding as the morse_tx input.
REQ-008 Port: busy  output  1  a letter is being emitted, including its gap cycles.
REQ-009 Port: err  output  1  one-cycle pulse on acceptance of an invalid code.

Function
REQ-010 Handshake: a letter SHALL be accepted on a rising edge where letter_valid = 1 and ready = 1; letter is sampled only at that edge.
REQ-011 States: IDLE, SYM, GAP; ready = 1 in IDLE and on the final GAP cycle, 0 otherwise.
REQ-012 IDLE: ditDah = 2'b01, busy = 0; acceptance of a valid code -> SYM.
REQ-013 Latency: the first symbol SHALL appear on ditDah at the accepting edge (registered output, visible the following cycle).
REQ-014 SYM: one symbol per cycle, first-sent symbol first, per the ITU Morse table for a..z and 0..9 (lengths 1..5); SPACE = dit dit dah dah.
REQ-015 After the last symbol, ditDah = 2'b01 for exactly GAP_CYCLES cycles (GAP state), then IDLE unless a new letter is accepted.
REQ-016 Back-to-back: acceptance on the final GAP cycle SHALL output the new first symbol on the next cycle, with no extra etc cycle; sustained throughput = one letter per (L + GAP_CYCLES) cycles.
REQ-017 Pattern storage: symbol bits and a 3-bit length SHALL be latched at acceptance; changes on letter after acceptance have no effect.
REQ-018 Invalid code (37..63): accepted per REQ-010, err = 1 for the following cycle, no symbols emitted, ditDah stays 2'b01, state stays IDLE (ready = 1).
REQ-019 Invalid code accepted on the final GAP cycle: same as REQ-018; the state returns to IDLE.
REQ-020 letter_valid = 1 while ready = 0 SHALL be ignored and not queued.
REQ-021 busy = 1 in SYM and GAP, 0 in IDLE.

Reset
REQ-022 rst_n = 0 SHALL immediately (asynchronously) force: state IDLE, ditDah = 2'b01, busy = 0, err = 0, ready = 1, symbol/length/gap counters cleared.
REQ-023 Reset mid-letter SHALL abort the letter; no remaining symbols are emitted after release.
REQ-024 First acceptance is possible on the first rising edge after rst_n deasserts.

Verification
REQ-025 'h' (7), GAP_CYCLES = 1 -> ditDah 00,00,00,00,01, then 01 idle; busy high for 5 cycles; ready high only on the 01 cycle.
REQ-026 'l' (11) then 'l' back-to-back, letter_valid held -> 00,11,00,00,01,00,11,00,00,01 with no extra separator.
REQ-027 SPACE (36) followed by 'e' (4) -> 00,00,11,11,01,00,01.
REQ-028 Invalid code 50 while idle -> err = 1 for one cycle, ditDah constant 01, busy = 0, ready = 1.
REQ-029 'o' (14) accepted, rst_n pulsed low after the second dah -> ditDah = 01 immediately, no third dah, ready = 1 after release.
REQ-030 GAP_CYCLES = 3, 'd' (3) -> 11,00,00,01,01,01; ready high only on the third 01.
